// File: rtl/score4_move_player.sv
// Scripted score4 move source: converts a column request into left/right/put button pulses.
// Optional 4-entry request queue enabled by defining SCORE4_MOVE_QUEUE_EN.
module score4_move_player #(
    parameter int unsigned COLS         = 7,
    parameter int unsigned START_COL    = 0,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned RESP_CYCLES  = 2,
    localparam int unsigned CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    input  logic [CW-1:0] i_req_col,
    output logic          o_req_ready,
    input  logic          i_invalid_move,
    input  logic          i_win_a,
    input  logic          i_win_b,
    output logic          o_left,
    output logic          o_right,
    output logic          o_put,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rejected,
    output logic [CW-1:0] o_cursor_col
);

    localparam int unsigned MAX_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_D = (MAX_A > RESP_CYCLES) ? MAX_A : RESP_CYCLES;
    localparam int unsigned CNTW  = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    localparam logic [CW:0]   COLS_W    = (CW+1)'(COLS);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [CW-1:0] HOME_COL  = CW'(START_COL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_PUT_HI  = 3'd4,
        S_PUT_LO  = 3'd5,
        S_RESP    = 3'd6,
        S_REPORT  = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic [CW-1:0]   r_target;
    logic [CW-1:0]   r_cursor;
    logic            r_fail;

    logic            w_game_over;
    logic            w_cnt_done;
    logic            w_target_bad;
    logic            w_dir_right;
    logic            w_start;
    logic [CW-1:0]   w_start_col;
    logic            w_busy;
    logic            w_ready;

    assign w_game_over  = i_win_a | i_win_b;
    assign w_cnt_done   = (r_cnt == '0);
    assign w_target_bad = ({1'b0, r_target} >= COLS_W);
    assign w_dir_right  = (r_target > r_cursor);
    assign o_cursor_col = r_cursor;

    // Dwell time of each timed state, loaded as (cycles - 1) on state entry.
    function automatic logic [CNTW-1:0] f_dur(input state_t s);
        logic [CNTW-1:0] d;
        d = '0;
        case (s)
            S_STEP_HI, S_PUT_HI: d = CNTW'(PULSE_CYCLES - 1);
            S_STEP_LO, S_PUT_LO: d = CNTW'(GAP_CYCLES - 1);
            S_RESP:              d = CNTW'(RESP_CYCLES - 1);
            default:             d = '0;
        endcase
        return d;
    endfunction

`ifdef SCORE4_MOVE_QUEUE_EN
    localparam int unsigned QD = 4;
    localparam int unsigned QW = 2;

    logic [CW-1:0] r_fifo [QD];
    logic [QW-1:0] r_wr;
    logic [QW-1:0] r_rd;
    logic [QW:0]   r_count;
    logic          w_push;
    logic          w_full;
    logic          w_empty;

    assign w_full      = (r_count == (QW+1)'(QD));
    assign w_empty     = (r_count == '0);
    assign w_ready     = ~w_full & ~w_game_over;
    assign w_push      = i_req_valid & w_ready;
    assign w_start     = (r_state == S_IDLE) & ~w_empty & ~w_game_over;
    assign w_start_col = r_fifo[r_rd];
    assign w_busy      = (r_state != S_IDLE) | ~w_empty;

    // Request FIFO; a game-over flushes every queued request.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_game_over) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr] <= i_req_col;
                r_wr         <= r_wr + QW'(1);
            end
            if (w_start) begin
                r_rd <= r_rd + QW'(1);
            end
            case ({w_push, w_start})
                2'b10:   r_count <= r_count + (QW+1)'(1);
                2'b01:   r_count <= r_count - (QW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign w_busy      = (r_state != S_IDLE);
    assign w_ready     = ~w_busy & ~w_game_over;
    assign w_start     = i_req_valid & w_ready;
    assign w_start_col = i_req_col;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_target_bad || w_game_over) w_next = S_REPORT;
                else if (r_target == r_cursor)   w_next = S_PUT_HI;
                else                             w_next = S_STEP_HI;
            end
            S_STEP_HI: begin
                if (w_cnt_done) w_next = S_STEP_LO;
            end
            S_STEP_LO: begin
                // A game-over seen at any point aborts the remaining steps and the put.
                if (w_cnt_done) begin
                    if (w_game_over || r_fail)   w_next = S_REPORT;
                    else if (r_cursor != r_target) w_next = S_STEP_HI;
                    else                         w_next = S_PUT_HI;
                end
            end
            S_PUT_HI: begin
                if (w_cnt_done) w_next = S_PUT_LO;
            end
            S_PUT_LO: begin
                if (w_cnt_done) w_next = S_RESP;
            end
            S_RESP: begin
                if (w_cnt_done) w_next = S_REPORT;
            end
            S_REPORT: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_left      = 1'b0;
        o_right     = 1'b0;
        o_put       = 1'b0;
        o_done      = 1'b0;
        o_rejected  = 1'b0;
        o_busy      = w_busy;
        o_req_ready = w_ready;
        case (r_state)
            S_STEP_HI: begin
                o_left  = ~w_dir_right;
                o_right = w_dir_right;
            end
            S_PUT_HI: o_put = 1'b1;
            S_REPORT: begin
                o_done     = ~r_fail;
                o_rejected = r_fail;
            end
            default: ;
        endcase
    end

    // Dwell counter, reloaded on every state change
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= f_dur(w_next);
        end else if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    // Target, sticky failure flag and local cursor model
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target <= '0;
            r_fail   <= 1'b0;
            r_cursor <= HOME_COL;
        end else begin
            if (w_start) begin
                r_target <= w_start_col;
                r_fail   <= 1'b0;
            end else if (((r_state == S_CHECK) && w_target_bad) ||
                         ((r_state == S_RESP) && i_invalid_move) ||
                         ((r_state != S_IDLE) && w_game_over)) begin
                r_fail <= 1'b1;
            end
            if ((r_state == S_STEP_HI) && w_cnt_done) begin
                if (w_dir_right && (r_cursor < LAST_COL)) begin
                    r_cursor <= r_cursor + CW'(1);
                end else if (!w_dir_right && (r_cursor != '0)) begin
                    r_cursor <= r_cursor - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_score4_move_player.sv
// Directed bench for score4_move_player (default build, COLS=7, START_COL=0, 1/2/2 timing).
module tb_score4_move_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_col;
    logic       req_ready;
    logic       invalid_move;
    logic       win_a;
    logic       win_b;
    logic       left;
    logic       right;
    logic       put;
    logic       busy;
    logic       done;
    logic       rejected;
    logic [2:0] cursor_col;

    int n_checks = 0;
    int n_fail   = 0;

    int left_rise  = 0;
    int right_rise = 0;
    int put_rise   = 0;
    int hi_cycles  = 0;
    int overlap    = 0;
    logic pl = 1'b0;
    logic pr = 1'b0;
    logic pp = 1'b0;

    score4_move_player #(
        .COLS(7), .START_COL(0), .PULSE_CYCLES(1), .GAP_CYCLES(2), .RESP_CYCLES(2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_col      (req_col),
        .o_req_ready    (req_ready),
        .i_invalid_move (invalid_move),
        .i_win_a        (win_a),
        .i_win_b        (win_b),
        .o_left         (left),
        .o_right        (right),
        .o_put          (put),
        .o_busy         (busy),
        .o_done         (done),
        .o_rejected     (rejected),
        .o_cursor_col   (cursor_col)
    );

    always #5 clk = ~clk;

    // Button activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (left  && !pl) left_rise++;
        if (right && !pr) right_rise++;
        if (put   && !pp) put_rise++;
        if (left || right || put) hi_cycles++;
        if ((32'(left) + 32'(right) + 32'(put)) > 1) overlap++;
        pl = left;
        pr = right;
        pp = put;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic [2:0] col, input int exp_lat,
                          input int exp_done, input int exp_rej, input int exp_cur,
                          input int exp_l, input int exp_r, input int exp_p,
                          input int inv_at, input int win_at);
        int l0, r0, p0, h0, o0, k;
        bit seen;
        l0 = left_rise; r0 = right_rise; p0 = put_rise; h0 = hi_cycles; o0 = overlap;
        req_valid = 1'b1;
        req_col   = col;
        tick();
        req_valid = 1'b0;
        chk({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        chk({tag, ".ready_after_accept"}, 32'(req_ready), 32'd0);
        k = 0;
        seen = 1'b0;
        while (k < 80 && !seen) begin
            tick();
            k++;
            if (done || rejected) seen = 1'b1;
            else begin
                invalid_move = (k == inv_at);
                if (k == win_at) win_a = 1'b1;
            end
        end
        invalid_move = 1'b0;
        chk({tag, ".latency"}, 32'(k), 32'(exp_lat));
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
        chk({tag, ".rejected"}, 32'(rejected), 32'(exp_rej));
        tick();
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk({tag, ".done_pulse_1cyc"}, 32'(done | rejected), 32'd0);
        chk({tag, ".cursor"}, 32'(cursor_col), 32'(exp_cur));
        chk({tag, ".left_pulses"}, 32'(left_rise - l0), 32'(exp_l));
        chk({tag, ".right_pulses"}, 32'(right_rise - r0), 32'(exp_r));
        chk({tag, ".put_pulses"}, 32'(put_rise - p0), 32'(exp_p));
        chk({tag, ".hi_cycles"}, 32'(hi_cycles - h0), 32'(exp_l + exp_r + exp_p));
        chk({tag, ".overlap"}, 32'(overlap - o0), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_col = 3'd0;
        invalid_move = 1'b0; win_a = 1'b0; win_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.ready", 32'(req_ready), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.buttons", 32'({left, right, put}), 32'd0);
        chk("reset.report", 32'({done, rejected}), 32'd0);
        chk("reset.cursor", 32'(cursor_col), 32'd0);

        // name, col, latency, done, rej, cursor, left, right, put, inv_at, win_at
        do_req("right3",   3'd3, 15, 1, 0, 3, 0, 3, 1, 0, 0);
        do_req("right2",   3'd5, 12, 1, 0, 5, 0, 2, 1, 0, 0);
        do_req("left4",    3'd1, 18, 1, 0, 1, 4, 0, 1, 0, 0);
        do_req("col7",     3'd7,  1, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("same_col", 3'd1,  6, 1, 0, 1, 0, 0, 1, 0, 0);
        do_req("inv_resp", 3'd2,  9, 0, 1, 2, 0, 1, 1, 7, 0);
        do_req("inv_early",3'd4, 12, 1, 0, 4, 0, 2, 1, 1, 0);
        do_req("win_mid",  3'd0,  7, 0, 1, 2, 2, 0, 0, 0, 4);

        chk("game_over.ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_col   = 3'd5;
        tick();
        req_valid = 1'b0;
        chk("game_over.no_accept", 32'(busy), 32'd0);
        win_a = 1'b0;
        tick();
        chk("game_over.ready_back", 32'(req_ready), 32'd1);

        // Reset in the middle of a step pulse
        req_valid = 1'b1;
        req_col   = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst_mid.right_hi", 32'(right), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid.buttons", 32'({left, right, put}), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.ready", 32'(req_ready), 32'd1);
        chk("rst_mid.cursor", 32'(cursor_col), 32'd0);
        rst = 1'b0;
        tick();

        do_req("after_rst", 3'd1, 9, 1, 0, 1, 0, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
